// File: rtl/bcd_seg_display.sv
// bcd_seg_display: sequential double-dabble binary-to-BCD converter with registered
// active-low 7-segment outputs, optional leading-zero blanking and 9..9 saturation.
module bcd_seg_display #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);
  localparam int BW = 4 * DIGITS;
  localparam int SW = 7 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  function automatic int max_dec(input int n);
    int m;
    m = 1;
    for (int i = 0; i < n; i++) m *= 10;
    return m - 1;
  endfunction

  localparam int MAXV = max_dec(DIGITS);

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0011000;
      default: return 7'b1111111;
    endcase
  endfunction

  // z tracks "this digit and every higher digit is zero", scanning from the top
  function automatic logic [SW-1:0] seg_of(input logic [BW-1:0] b);
    logic [SW-1:0] r;
    logic z;
    r = '0;
    z = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      z = z && (b[4*k+:4] == 4'd0);
      r[7*k+:7] = (BLANK_LZ != 0 && k > 0 && z) ? 7'h7f : dec7(b[4*k+:4]);
    end
    return r;
  endfunction

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]   scr_q, scr_d, adj, bcd_q, bcd_d;
  logic [SW-1:0]   seg_q, seg_d;
  logic            pend_q, pend_d, done_q, done_d, ovf_q, ovf_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    bcd_d   = bcd_q;
    seg_d   = seg_q;
    adj     = scr_q;
    for (int k = 0; k < DIGITS; k++)
      adj[4*k+:4] = (scr_q[4*k+:4] >= 4'd5) ? scr_q[4*k+:4] + 4'd3 : scr_q[4*k+:4];
    if (state_q == IDLE) begin
      if (start) begin
        state_d = SHIFT;
        bin_d   = value;
        scr_d   = '0;
        cnt_d   = CW'(WIDTH);
        pend_d  = int'(value) > MAXV;
      end
    end else begin
      bin_d = bin_q << 1;
      scr_d = {adj[BW-2:0], bin_q[WIDTH-1]};
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
        ovf_d   = pend_q;
        bcd_d   = pend_q ? {DIGITS{4'h9}} : {adj[BW-2:0], bin_q[WIDTH-1]};
        seg_d   = seg_of(bcd_d);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      scr_q   <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
      seg_q   <= seg_of('0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      bcd_q   <= bcd_d;
      seg_q   <= seg_d;
    end
  end

  assign busy     = state_q == SHIFT;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign bcd      = bcd_q;
  assign seg      = seg_q;
endmodule

// File: tb/tb_bcd_seg_display.sv
// tb_bcd_seg_display: three configurations (3 digits blanked, 3 digits unblanked,
// 2 digits blanked) share one stimulus stream and are checked against a decimal model.
module tb_bcd_seg_display;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] value = '0;
  logic busy_a, done_a, ovf_a, busy_b, done_b, ovf_b, busy_c, done_c, ovf_c;
  logic [11:0] bcd_a, bcd_b;
  logic [20:0] seg_a, seg_b;
  logic [7:0]  bcd_c;
  logic [13:0] seg_c;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  bcd_seg_display #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .value(value), .busy(busy_a), .done(done_a),
    .overflow(ovf_a), .bcd(bcd_a), .seg(seg_a));
  bcd_seg_display #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .value(value), .busy(busy_b), .done(done_b),
    .overflow(ovf_b), .bcd(bcd_b), .seg(seg_b));
  bcd_seg_display #(.WIDTH(8), .DIGITS(2), .BLANK_LZ(1)) dut_c (
    .clk(clk), .rst(rst), .start(start), .value(value), .busy(busy_c), .done(done_c),
    .overflow(ovf_c), .bcd(bcd_c), .seg(seg_c));

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
    S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010, S7 = 7'b1111000,
    S9 = 7'b0011000, SB = 7'b1111111;
  logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

  typedef struct {
    logic [7:0]  v;
    logic [11:0] ab;
    logic [20:0] as;
    logic [7:0]  cb;
    logic [13:0] cs;
    logic        co;
  } vec_t;
  vec_t tab [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int p10(input int n);
    int m;
    m = 1;
    for (int i = 0; i < n; i++) m *= 10;
    return m;
  endfunction

  // decimal reference: digits by division, blanking by magnitude, saturation by range
  task automatic model(input int v, input int d, input bit blank,
                       output logic [19:0] b, output logic [34:0] s, output logic o);
    int dig;
    o = v >= p10(d);
    b = '0;
    s = '0;
    for (int k = 0; k < d; k++) begin
      dig = o ? 9 : (v / p10(k)) % 10;
      b[4*k+:4] = 4'(dig);
      s[7*k+:7] = (blank && !o && k > 0 && v < p10(k)) ? SB : segtab[dig];
    end
  endtask

  task automatic cmp_all(input int v);
    logic [19:0] b;
    logic [34:0] s;
    logic o;
    model(v, 3, 1'b1, b, s, o);
    chk($sformatf("a_bcd(%0d)", v), 64'(bcd_a), 64'(b));
    chk($sformatf("a_seg(%0d)", v), 64'(seg_a), 64'(s));
    chk($sformatf("a_ovf(%0d)", v), 64'(ovf_a), 64'(o));
    model(v, 3, 1'b0, b, s, o);
    chk($sformatf("b_bcd(%0d)", v), 64'(bcd_b), 64'(b));
    chk($sformatf("b_seg(%0d)", v), 64'(seg_b), 64'(s));
    model(v, 2, 1'b1, b, s, o);
    chk($sformatf("c_bcd(%0d)", v), 64'(bcd_c), 64'(b));
    chk($sformatf("c_seg(%0d)", v), 64'(seg_c), 64'(s));
    chk($sformatf("c_ovf(%0d)", v), 64'(ovf_c), 64'(o));
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done_a && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  // accept v, scramble value afterwards, and measure busy cycles and done latency
  task automatic run(input logic [7:0] v, input bit chk_lat);
    int lat, nb;
    @(negedge clk);
    value = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    value = ~v;
    lat = 0;
    nb = 0;
    while (!done_a && lat < 40) begin
      if (busy_a) nb++;
      @(negedge clk);
      lat++;
    end
    if (chk_lat) begin
      chk($sformatf("latency(%0d)", v), 64'(lat), 64'd8);
      chk($sformatf("busy_cycles(%0d)", v), 64'(nb), 64'd8);
      chk($sformatf("busy_at_done(%0d)", v), 64'(busy_a), 64'd0);
    end else if (lat != 8) begin
      chk($sformatf("latency(%0d)", v), 64'(lat), 64'd8);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 64'({busy_a, busy_b, busy_c}), 64'd0);
    chk({tag, "_done"}, 64'({done_a, done_b, done_c}), 64'd0);
    chk({tag, "_ovf"}, 64'({ovf_a, ovf_b, ovf_c}), 64'd0);
    chk({tag, "_bcd"}, 64'({bcd_a, bcd_b, bcd_c}), 64'd0);
    chk({tag, "_seg_a"}, 64'(seg_a), 64'({SB, SB, S0}));
    chk({tag, "_seg_b"}, 64'(seg_b), 64'({S0, S0, S0}));
    chk({tag, "_seg_c"}, 64'(seg_c), 64'({SB, S0}));
  endtask

  initial begin
    int n, n2, pulses;
    logic [7:0] rv;
    tab[0] = '{8'd255, 12'h255, {S2, S5, S5}, 8'h99, {S9, S9}, 1'b1};
    tab[1] = '{8'd7,   12'h007, {SB, SB, S7}, 8'h07, {SB, S7}, 1'b0};
    tab[2] = '{8'd0,   12'h000, {SB, SB, S0}, 8'h00, {SB, S0}, 1'b0};
    tab[3] = '{8'd100, 12'h100, {S1, S0, S0}, 8'h99, {S9, S9}, 1'b1};
    tab[4] = '{8'd42,  12'h042, {SB, S4, S2}, 8'h42, {S4, S2}, 1'b0};
    tab[5] = '{8'd123, 12'h123, {S1, S2, S3}, 8'h99, {S9, S9}, 1'b1};

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset("reset");

    for (int i = 0; i < 6; i++) begin
      run(tab[i].v, 1'b1);
      chk($sformatf("tab_a_bcd(%0d)", tab[i].v), 64'(bcd_a), 64'(tab[i].ab));
      chk($sformatf("tab_a_seg(%0d)", tab[i].v), 64'(seg_a), 64'(tab[i].as));
      chk($sformatf("tab_c_bcd(%0d)", tab[i].v), 64'(bcd_c), 64'(tab[i].cb));
      chk($sformatf("tab_c_seg(%0d)", tab[i].v), 64'(seg_c), 64'(tab[i].cs));
      chk($sformatf("tab_c_ovf(%0d)", tab[i].v), 64'(ovf_c), 64'(tab[i].co));
      cmp_all(tab[i].v);
      @(negedge clk);
      chk($sformatf("done_pulse(%0d)", tab[i].v), 64'(done_a), 64'd0);
      chk($sformatf("hold_a_bcd(%0d)", tab[i].v), 64'(bcd_a), 64'(tab[i].ab));
    end

    for (int i = 0; i < 24; i++) begin
      rv = 8'($urandom_range(0, 255));
      run(rv, 1'b1);
      cmp_all(int'(rv));
    end

    // start mid-conversion is dropped; start in the done cycle is taken
    @(negedge clk);
    value = 8'd123;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    value = 8'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk("ignored_start_latency", 64'(n), 64'd4);
    chk("ignored_start_bcd", 64'(bcd_a), 64'h123);
    value = 8'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 64'(busy_a), 64'd1);
    wait_done(n2);
    chk("b2b_gap", 64'(n2 + 1), 64'd9);
    cmp_all(200);
    chk("b2b_bcd", 64'(bcd_a), 64'h200);

    // reset aborts an in-flight conversion
    run(8'd99, 1'b1);
    cmp_all(99);
    @(negedge clk);
    value = 8'd250;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("abort");
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_a || done_b || done_c) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);

    for (int v = 0; v < 256; v++) begin
      run(8'(v), 1'b0);
      cmp_all(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd_seg_display.md
Name: bcd_seg_display

Overview:
- Parametrised successor to the 2-digit hex-to-7-segment decoder; drives the HP, damage and accuracy readouts on the HEX displays.
- Converts an unsigned WIDTH-bit binary value to DIGITS decimal digits with a sequential double-dabble (shift/add-3) engine, one shift per clock.
- Registers the BCD and active-low 7-segment patterns for every digit, with optional leading-zero blanking and decimal saturation on overflow.

Parameters:
WIDTH, 8, bit width of the binary input value (1..16)
DIGITS, 3, number of decimal digits produced (1..5)
BLANK_LZ, 1, 1 = blank leading zero digits, 0 = show all zeros

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request conversion of value; sampled only when busy=0
value  input  WIDTH  unsigned binary value, sampled on the accepting edge
busy  output  1  conversion in progress
done  output  1  one-cycle pulse when new results are registered
overflow  output  1  last accepted value exceeded 10^DIGITS-1
bcd  output  4*DIGITS  BCD result; digit k at bits [4k+3:4k], k=0 least significant
seg  output  7*DIGITS  active-low segments; digit k at bits [7k+6:7k], bit order {g,f,e,d,c,b,a}

Behaviour:
- Reset: clk and rst are as decided above (one clock, synchronous active-high reset).
  - On reset: busy=0, done=0, overflow=0, bcd=0, internal counter and shift register cleared.
  - seg after reset: digit0=7'b1000000. Digits 1..DIGITS-1 are 7'b1111111 if BLANK_LZ=1, else 7'b1000000.
  - rst has priority over every other input. Reset during a conversion aborts it: no done pulse, outputs take reset values.
- States: IDLE, SHIFT.
- IDLE, start=1 at an edge (the accept edge):
  - Latch value into the binary shift register and clear the BCD scratch register.
  - Load the iteration counter with WIDTH.
  - Compute overflow_next = (value > 10^DIGITS-1) as a constant compare.
  - Go to SHIFT; busy=1 from this edge.
- SHIFT, each edge:
  - Every scratch digit >=5 gets +3.
  - Then shift {scratch, binary} left by 1; counter decrements.
- Final shift (counter==1 before the edge), on that same edge:
  - bcd <= adjusted/shifted scratch, or all digits 4'h9 if overflow_next.
  - overflow <= overflow_next; seg <= decoded pattern; done <= 1; busy <= 0; state <= IDLE.
- Latency: done is high in the cycle following edge WIDTH after the accept edge (accept edge = edge 0). Exactly WIDTH cycles busy.
- done is high for exactly one cycle; otherwise 0.
- bcd, seg and overflow hold their previous values until the done edge; no intermediate values are visible.
- start while busy=1 is ignored and not queued.
- start in the cycle done=1 is accepted (state is IDLE): back-to-back conversions every WIDTH+1 cycles.
- value changes after the accept edge have no effect.
- Digit decode (active-low), 0..9:
  - 1000000, 1111001, 0100100, 0110000, 0011001
  - 0010010, 0000010, 1111000, 0000000, 0011000
- Leading-zero blanking (BLANK_LZ=1):
  - Digit k>0 outputs 1111111 when it and all higher digits are 0.
  - digit0 is never blanked, so value 0 shows a single "0".
  - In overflow no digit is blanked (all show 9).

Test Plan:
- WIDTH=8, DIGITS=3, BLANK_LZ=1: reset, then start with value=255 → busy for 8 cycles, then done=1 for 1 cycle, bcd=12'h255, seg={0100100,0010010,0010010}, overflow=0.
- Same config, value=7 → bcd=12'h007, seg[20:7]=all 1s, seg[6:0]=1111000. Repeat with BLANK_LZ=0 → seg[20:7]={1000000,1000000}. Then value=0 → seg[6:0]=1000000, upper digits blank.
- WIDTH=8, DIGITS=2: value=100 → overflow=1, bcd=8'h99, seg={0011000,0011000}. Next value=42 → overflow=0, bcd=8'h42.
- value=123 accepted, start pulsed again with value=9 at cycle 3 → ignored; single done, bcd=12'h123. Then start asserted in the done cycle with value=200 → accepted; second done exactly 9 cycles after the first, bcd=12'h200.
- Conversion of 99 completes; then value=250 starts and rst=1 at cycle 4 → no done pulse, busy=0, bcd=0, seg=reset pattern, overflow=0 the cycle after reset.
- Exhaustive sweep, WIDTH=8, DIGITS=3: values 0..255 → bcd matches reference decimal conversion for every value; latency 8 cycles for each.
